mem_port_arbiter: RTL and testbench

- Shares one downstream memory port between the instruction-fetch requester and the load/store requester.
- Arbitrates round-robin, latches the winning request, holds it on the memory port until the memory answers, then returns the result to the winner as a one-cycle valid pulse.
- Sits between the core's fetch/LSU handshakes and the memory controller's single request port. Includes a watchdog that aborts hung transactions.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_port_arbiter_rr.sv | 22 ++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, requester source
// encoding and memory operation lengths.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Encoding matches the existing core convention: 0 = fetch, 1 = load/store.
  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } src_t;

  localparam logic [1:0] OPLEN_B  = 2'd0;
  localparam logic [1:0] OPLEN_H  = 2'd1;
  localparam logic [1:0] OPLEN_3B = 2'd2;
  localparam logic [1:0] OPLEN_W  = 2'd3;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// source that did not win last time.
module rr_arbiter_2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,   // [0] = instr, [1] = data
  input  src_t       last,
  output logic       grant,
  output src_t       src
);

  always_comb begin
    grant = |req;
    src   = SRC_INSTR;
    if (req == 2'b11) begin
      src = (last == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
    end else if (req[1]) begin
      src = SRC_DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory request port between instruction fetch and load/store.
// Round-robin grant, hold until memory answers or the watchdog fires, then a one-cycle valid.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA   = DATA_W'(32'hDEADBEEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_oplen,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_enable,
  output logic [ADDR_W-1:0] m_addr,
  output logic [1:0]        m_oplen,
  output logic              m_we,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_valid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err_timeout,
  output logic              last_src,
  output state_t            fsm_state
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);

  state_t            state, state_nx;
  src_t              src_q, last_q, pick_src;
  logic              pick;
  logic [WD_W-1:0]   wd_cnt;
  logic              wd_expired;
  logic [DATA_W-1:0] result;
  logic              timed_out;

  rr_arbiter_2 u_rr (
    .req   ({d_req, i_req}),
    .last  (last_q),
    .grant (pick),
    .src   (pick_src)
  );

  // The current BUSY cycle is the TIMEOUT_CYCLES-th one without an answer.
  assign wd_expired = (wd_cnt >= WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick) state_nx = BUSY;
      BUSY:    if (m_valid || wd_expired) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q     <= SRC_INSTR;
      last_q    <= SRC_DATA;
      m_addr    <= '0;
      m_oplen   <= OPLEN_B;
      m_we      <= 1'b0;
      m_wdata   <= '0;
      wd_cnt    <= '0;
      result    <= '0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick) begin
            src_q     <= pick_src;
            last_q    <= pick_src;
            wd_cnt    <= '0;
            timed_out <= 1'b0;
            if (pick_src == SRC_INSTR) begin
              m_addr  <= i_addr;
              m_oplen <= OPLEN_W;
              m_we    <= 1'b0;
              m_wdata <= '0;
            end else begin
              m_addr  <= d_addr;
              m_oplen <= d_oplen;
              m_we    <= d_we;
              m_wdata <= d_wdata;
            end
          end
        end
        BUSY: begin
          // A real answer wins over a watchdog expiry in the same cycle.
          if (m_valid) begin
            result <= m_rdata;
          end else if (wd_expired) begin
            result    <= TIMEOUT_DATA;
            timed_out <= 1'b1;
          end
          if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign m_enable    = (state == BUSY);
  assign i_valid     = (state == DONE) && (src_q == SRC_INSTR);
  assign d_valid     = (state == DONE) && (src_q == SRC_DATA);
  assign i_rdata     = i_valid ? result : '0;
  assign d_rdata     = d_valid ? result : '0;
  assign err_timeout = (state == DONE) && timed_out;
  assign last_src    = last_q;
  assign fsm_state   = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level model of grants,
// memory latency and watchdog, with an expected-result queue.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int          AW      = 32;
  localparam int          DW      = 32;
  localparam int          TO      = 4;
  localparam logic [31:0] TO_DATA = 32'hDEADBEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_valid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_valid;
  logic [AW-1:0] d_addr;
  logic [1:0]    d_oplen;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_enable, m_we, m_valid;
  logic [AW-1:0] m_addr;
  logic [1:0]    m_oplen;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          err_timeout, last_src;
  state_t        fsm_state;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(TO_DATA)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_oplen(d_oplen), .d_we(d_we),
    .d_wdata(d_wdata), .d_valid(d_valid), .d_rdata(d_rdata),
    .m_enable(m_enable), .m_addr(m_addr), .m_oplen(m_oplen), .m_we(m_we),
    .m_wdata(m_wdata), .m_valid(m_valid), .m_rdata(m_rdata),
    .err_timeout(err_timeout), .last_src(last_src), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard: {timed_out, src, data} per completed transaction
  logic [DW+1:0] exp_q[$];

  // transaction-level model
  bit            busy, done_pending;
  src_t          cur_src, model_last;
  logic [AW-1:0] cur_addr;
  logic [1:0]    cur_oplen;
  logic          cur_we;
  logic [DW-1:0] cur_wdata;
  int            k, wait_n;

  // stimulus knobs
  bit en_i, en_d, hold, want_reset;
  int fixed_wait, max_wait;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic new_i();
    i_req  = 1'b1;
    i_addr = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic new_d();
    d_req   = 1'b1;
    d_addr  = $urandom;
    d_oplen = 2'($urandom_range(0, 3));
    d_we    = 1'($urandom_range(0, 1));
    d_wdata = $urandom;
  endtask

  task automatic raise_reqs();
    if (!i_req && en_i && (hold || $urandom_range(0, 1) == 1)) new_i();
    if (!d_req && en_d && (hold || $urandom_range(0, 1) == 1)) new_d();
  endtask

  // the requester that just saw its valid either drops or issues a new request
  task automatic serve(input src_t s);
    if (s == SRC_INSTR) begin
      if (en_i && (hold || $urandom_range(0, 1) == 1)) new_i();
      else i_req = 1'b0;
    end else begin
      if (en_d && (hold || $urandom_range(0, 1) == 1)) new_d();
      else d_req = 1'b0;
    end
  endtask

  task automatic grant_decide();
    if (i_req || d_req) begin
      if (i_req && d_req) cur_src = (model_last == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
      else                cur_src = i_req ? SRC_INSTR : SRC_DATA;
      if (cur_src == SRC_INSTR) begin
        cur_addr = i_addr; cur_oplen = OPLEN_W; cur_we = 1'b0; cur_wdata = '0;
      end else begin
        cur_addr = d_addr; cur_oplen = d_oplen; cur_we = d_we; cur_wdata = d_wdata;
      end
      model_last = cur_src;
      busy       = 1'b1;
      k          = 0;
      wait_n     = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, max_wait);
    end
  endtask

  // driver: one clock cycle -- check outputs at negedge, then drive next inputs
  task automatic step();
    logic [DW+1:0] e;
    state_t        exp_state;
    @(negedge clk);
    if (rst) begin
      check("rst_m_enable", m_enable, 0);
      check("rst_i_valid", i_valid, 0);
      check("rst_d_valid", d_valid, 0);
      check("rst_err", err_timeout, 0);
      check("rst_last_src", last_src, 1);
      check("rst_m_addr", m_addr, 0);
      rst = 1'b0;
      new_i();
      new_d();
      m_valid = 1'b0;
      grant_decide();
      return;
    end

    exp_state = done_pending ? DONE : (busy ? BUSY : IDLE);
    check("fsm_state", fsm_state, exp_state);
    check("m_enable", m_enable, busy);
    if (busy) begin
      check("m_addr", m_addr, cur_addr);
      check("m_oplen", m_oplen, cur_oplen);
      check("m_we", m_we, cur_we);
      if (cur_src == SRC_DATA) check("m_wdata", m_wdata, cur_wdata);
    end
    if (done_pending) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      check("i_valid", i_valid, e[DW] == 1'b0);
      check("d_valid", d_valid, e[DW] == 1'b1);
      check("err_timeout", err_timeout, e[DW+1]);
      if (e[DW] == 1'b0) check("i_rdata", i_rdata, e[DW-1:0]);
      else               check("d_rdata", d_rdata, e[DW-1:0]);
    end else begin
      check("i_valid_idle", i_valid, 0);
      check("d_valid_idle", d_valid, 0);
      check("err_idle", err_timeout, 0);
    end
    check("last_src", last_src, model_last);

    m_valid = 1'b0;
    m_rdata = $urandom;
    if (want_reset && busy && cur_src == SRC_DATA && k >= 1) begin
      // abandon an in-flight data transaction
      rst          = 1'b1;
      want_reset   = 1'b0;
      busy         = 1'b0;
      done_pending = 1'b0;
      model_last   = SRC_DATA;
      i_req        = 1'b0;
      d_req        = 1'b0;
      exp_q.delete();
      return;
    end

    if (done_pending) begin
      done_pending = 1'b0;
      serve(cur_src);
      m_valid = ($urandom_range(0, 2) == 0);
      raise_reqs();
    end else if (busy) begin
      if (k == wait_n) begin
        m_valid = 1'b1;
        exp_q.push_back({1'b0, cur_src, m_rdata});
        busy = 1'b0;
        done_pending = 1'b1;
      end else if (k == TO - 1) begin
        exp_q.push_back({1'b1, cur_src, TO_DATA});
        busy = 1'b0;
        done_pending = 1'b1;
      end
      k++;
      raise_reqs();
    end else begin
      m_valid = ($urandom_range(0, 2) == 0);
      raise_reqs();
      grant_decide();
    end
  endtask

  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_addr = '0; d_oplen = '0; d_we = 1'b0; d_wdata = '0;
    m_valid = 1'b0; m_rdata = '0;
    busy = 1'b0; done_pending = 1'b0; model_last = SRC_DATA;
    want_reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_m_enable", m_enable, 0);
    check("reset_i_valid", i_valid, 0);
    check("reset_d_valid", d_valid, 0);
    check("reset_err", err_timeout, 0);
    check("reset_last_src", last_src, 1);
    check("reset_m_addr", m_addr, 0);
    check("reset_m_oplen", m_oplen, 0);
    check("reset_m_we", m_we, 0);
    check("reset_m_wdata", m_wdata, 0);
    check("reset_state", fsm_state, IDLE);
    rst = 1'b0;

    // fetch only, memory answers after two BUSY cycles
    en_i = 1; en_d = 0; hold = 0; fixed_wait = 2; max_wait = 0;
    repeat (40) step();
    // both requesters held: strict alternation
    en_i = 1; en_d = 1; hold = 1; fixed_wait = -1; max_wait = 3;
    repeat (80) step();
    // back-to-back fetch on zero-wait memory
    en_i = 1; en_d = 0; hold = 1; fixed_wait = 0;
    repeat (40) step();
    // random traffic with timeouts and mid-transaction resets
    en_i = 1; en_d = 1; hold = 0; fixed_wait = -1; max_wait = 5;
    for (int n = 0; n < 1500; n++) begin
      if (n == 300 || n == 900) want_reset = 1'b1;
      step();
    end
    // drain
    en_i = 0; en_d = 0; hold = 0;
    repeat (30) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
